// File: rtl/escalonador_quadro_if.sv
// Bundle of the per-frame game-state controller signals.
// Slave side (the controller) receives the frame pulse, the run flag and the
// button levels, and drives every object coordinate, radius and status flag.
// Master side (renderer / input logic / bench) is the mirror image.
//   inicio_quadro, ativo, botao_esq, botao_dir, botao_tiro : master -> slave
//   x/y_nave, x/y_inimigo, x/y/raio_bola_aliada,
//   x/y/raio_bola_inimiga, pontos, perdeu, ocupado          : slave -> master
interface escalonador_quadro_if;
  logic       inicio_quadro;
  logic       ativo;
  logic       botao_esq;
  logic       botao_dir;
  logic       botao_tiro;
  logic [9:0] x_nave;
  logic [9:0] y_nave;
  logic [9:0] x_inimigo;
  logic [9:0] y_inimigo;
  logic [9:0] x_bola_aliada;
  logic [9:0] y_bola_aliada;
  logic [9:0] raio_bola_aliada;
  logic [9:0] x_bola_inimiga;
  logic [9:0] y_bola_inimiga;
  logic [9:0] raio_bola_inimiga;
  logic [7:0] pontos;
  logic       perdeu;
  logic       ocupado;

  modport slave (
    input  inicio_quadro, ativo, botao_esq, botao_dir, botao_tiro,
    output x_nave, y_nave, x_inimigo, y_inimigo,
           x_bola_aliada, y_bola_aliada, raio_bola_aliada,
           x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
           pontos, perdeu, ocupado
  );

  modport master (
    output inicio_quadro, ativo, botao_esq, botao_dir, botao_tiro,
    input  x_nave, y_nave, x_inimigo, y_inimigo,
           x_bola_aliada, y_bola_aliada, raio_bola_aliada,
           x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
           pontos, perdeu, ocupado
  );
endinterface

// File: rtl/escalonador_quadro.sv
// Per-frame game-state controller for the shooter display.
// A one-cycle inicio_quadro pulse (while ativo=1 and perdeu=0) runs a fixed
// five-cycle update: ship, ally shot, enemy, enemy shot, collisions.
// Ports:
//   CLOCK_50 : system clock, all state changes on the rising edge
//   reset    : synchronous, active-high
//   bus      : controller side of escalonador_quadro_if (inputs: frame pulse,
//              run flag, buttons; outputs: coordinates in active-area pixels,
//              radii, pontos, perdeu, ocupado)
module escalonador_quadro #(
  parameter logic [9:0] VEL_NAVE         = 10'd4,
  parameter logic [9:0] VEL_TIRO         = 10'd8,
  parameter logic [9:0] VEL_INIMIGO      = 10'd2,
  parameter logic [9:0] VEL_TIRO_INIMIGO = 10'd4,
  parameter logic [5:0] PERIODO_TIRO     = 6'd60,
  parameter logic [9:0] LARGURA_OBJ      = 10'd30,
  parameter logic [9:0] ALTURA_OBJ       = 10'd32,
  parameter logic [9:0] RAIO             = 10'd4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  escalonador_quadro_if.slave  bus
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    NAVE     = 3'd1,
    TIRO     = 3'd2,
    INIMIGO  = 3'd3,
    TIRO_INI = 3'd4,
    COLISAO  = 3'd5
  } estado_t;

  localparam logic [9:0] Y_NAVE    = 10'd440;
  localparam logic [9:0] Y_INIMIGO = 10'd40;
  localparam logic [9:0] X_MAX     = 10'd640 - LARGURA_OBJ;
  localparam logic [9:0] Y_LIMITE  = 10'd475;
  localparam logic [5:0] CNT_MAX   = PERIODO_TIRO - 6'd1;

  estado_t    estado_q, estado_d;
  logic [9:0] x_nave_q, x_nave_d;
  logic [9:0] x_ini_q, x_ini_d;
  logic       dir_dir_q, dir_dir_d;      // 1: enemy moving right
  logic [9:0] xa_q, xa_d, ya_q, ya_d;
  logic       ativa_a_q, ativa_a_d;
  logic [9:0] xi_q, xi_d, yi_q, yi_d;
  logic       ativa_i_q, ativa_i_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] pontos_q, pontos_d;
  logic       perdeu_q, perdeu_d;

  logic [9:0] x_ini_soma;
  logic       acerto_a, acerto_i;

  // State register and all game registers; reset overrides any state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      x_nave_q  <= 10'd305;
      x_ini_q   <= 10'd0;
      dir_dir_q <= 1'b1;
      xa_q      <= 10'd0;
      ya_q      <= 10'd0;
      ativa_a_q <= 1'b0;
      xi_q      <= 10'd0;
      yi_q      <= 10'd0;
      ativa_i_q <= 1'b0;
      cnt_q     <= 6'd0;
      pontos_q  <= 8'd0;
      perdeu_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      x_nave_q  <= x_nave_d;
      x_ini_q   <= x_ini_d;
      dir_dir_q <= dir_dir_d;
      xa_q      <= xa_d;
      ya_q      <= ya_d;
      ativa_a_q <= ativa_a_d;
      xi_q      <= xi_d;
      yi_q      <= yi_d;
      ativa_i_q <= ativa_i_d;
      cnt_q     <= cnt_d;
      pontos_q  <= pontos_d;
      perdeu_q  <= perdeu_d;
    end
  end

  // Half-open box tests on the shot centers, used only in COLISAO.
  always_comb begin
    acerto_a = ativa_a_q
            && (xa_q >= x_ini_q) && (xa_q < x_ini_q + LARGURA_OBJ)
            && (ya_q >= Y_INIMIGO) && (ya_q < Y_INIMIGO + ALTURA_OBJ);
    acerto_i = ativa_i_q
            && (xi_q >= x_nave_q) && (xi_q < x_nave_q + LARGURA_OBJ)
            && (yi_q >= Y_NAVE) && (yi_q < Y_NAVE + ALTURA_OBJ);
    x_ini_soma = x_ini_q + VEL_INIMIGO;
  end

  // Next-state sequencing and per-state object updates.
  always_comb begin
    estado_d  = estado_q;
    x_nave_d  = x_nave_q;
    x_ini_d   = x_ini_q;
    dir_dir_d = dir_dir_q;
    xa_d      = xa_q;
    ya_d      = ya_q;
    ativa_a_d = ativa_a_q;
    xi_d      = xi_q;
    yi_d      = yi_q;
    ativa_i_d = ativa_i_q;
    cnt_d     = cnt_q;
    pontos_d  = pontos_q;
    perdeu_d  = perdeu_q;

    case (estado_q)
      OCIOSO: begin
        if (bus.inicio_quadro && bus.ativo && !perdeu_q) begin
          estado_d = NAVE;
        end else begin
          estado_d = OCIOSO;
        end
      end
      NAVE: begin
        estado_d = TIRO;
        if (bus.botao_dir && !bus.botao_esq) begin
          // Compare before adding so the clamp never sees a wrapped value.
          if (x_nave_q >= X_MAX - VEL_NAVE) x_nave_d = X_MAX;
          else                              x_nave_d = x_nave_q + VEL_NAVE;
        end else if (bus.botao_esq && !bus.botao_dir) begin
          if (x_nave_q < VEL_NAVE) x_nave_d = 10'd0;
          else                     x_nave_d = x_nave_q - VEL_NAVE;
        end else begin
          x_nave_d = x_nave_q;
        end
      end
      TIRO: begin
        estado_d = INIMIGO;
        if (ativa_a_q) begin
          if (ya_q < VEL_TIRO) ativa_a_d = 1'b0;
          else                 ya_d      = ya_q - VEL_TIRO;
        end else if (bus.botao_tiro) begin
          ativa_a_d = 1'b1;
          xa_d      = x_nave_q + (LARGURA_OBJ >> 1);
          ya_d      = Y_NAVE - RAIO;
        end else begin
          ativa_a_d = 1'b0;
        end
      end
      INIMIGO: begin
        estado_d = TIRO_INI;
        if (dir_dir_q) begin
          if (x_ini_soma >= X_MAX) begin
            x_ini_d   = X_MAX;
            dir_dir_d = 1'b0;
          end else begin
            x_ini_d = x_ini_soma;
          end
        end else begin
          if (x_ini_q <= VEL_INIMIGO) begin
            x_ini_d   = 10'd0;
            dir_dir_d = 1'b1;
          end else begin
            x_ini_d = x_ini_q - VEL_INIMIGO;
          end
        end
      end
      TIRO_INI: begin
        estado_d = COLISAO;
        // Spawn decision uses the activity seen on entry, before the move.
        if ((cnt_q == CNT_MAX) && !ativa_i_q) begin
          ativa_i_d = 1'b1;
          xi_d      = x_ini_q + (LARGURA_OBJ >> 1);
          yi_d      = Y_INIMIGO + ALTURA_OBJ;
          cnt_d     = 6'd0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 6'd1;
          else                  cnt_d = cnt_q;
          if (ativa_i_q) begin
            if (yi_q + VEL_TIRO_INIMIGO > Y_LIMITE) ativa_i_d = 1'b0;
            else                                    yi_d = yi_q + VEL_TIRO_INIMIGO;
          end else begin
            ativa_i_d = 1'b0;
          end
        end
      end
      COLISAO: begin
        estado_d = OCIOSO;
        if (acerto_a) begin
          ativa_a_d = 1'b0;
          if (pontos_q != 8'd255) pontos_d = pontos_q + 8'd1;
          else                    pontos_d = pontos_q;
        end else begin
          ativa_a_d = ativa_a_q;
        end
        if (acerto_i) begin
          ativa_i_d = 1'b0;
          perdeu_d  = 1'b1;
        end else begin
          ativa_i_d = ativa_i_q;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign bus.x_nave            = x_nave_q;
  assign bus.y_nave            = Y_NAVE;
  assign bus.x_inimigo         = x_ini_q;
  assign bus.y_inimigo         = Y_INIMIGO;
  assign bus.x_bola_aliada     = xa_q;
  assign bus.y_bola_aliada     = ya_q;
  assign bus.raio_bola_aliada  = ativa_a_q ? RAIO : 10'd0;
  assign bus.x_bola_inimiga    = xi_q;
  assign bus.y_bola_inimiga    = yi_q;
  assign bus.raio_bola_inimiga = ativa_i_q ? RAIO : 10'd0;
  assign bus.pontos            = pontos_q;
  assign bus.perdeu            = perdeu_q;
  assign bus.ocupado           = (estado_q != OCIOSO);

endmodule

// File: tb/tb_escalonador_quadro.sv
// Directed bench for escalonador_quadro: hand-computed frame-by-frame
// expectations for reset, ship clamping, ally shot flight, enemy bounce,
// enemy shot spawn, hit scoring, loss, dropped pulse and mid-sequence reset.
module tb_escalonador_quadro;
  logic CLOCK_50;
  logic reset;
  int   checks;
  int   errors;

  escalonador_quadro_if bus();

  escalonador_quadro dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One frame pulse, then wait (bounded) for the controller to go idle.
  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      int w;
      bus.inicio_quadro = 1'b1;
      tick();
      bus.inicio_quadro = 1'b0;
      w = 0;
      while (bus.ocupado && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) begin
        checks++;
        errors++;
        $error("FAIL frame_timeout observed busy expected idle");
      end
    end
  endtask

  initial begin
    int busy;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.inicio_quadro = 1'b0;
    bus.ativo      = 1'b1;
    bus.botao_esq  = 1'b0;
    bus.botao_dir  = 1'b0;
    bus.botao_tiro = 1'b0;
    tick();

    // Reset values
    do_reset();
    chk("rst_x_nave", bus.x_nave, 305);
    chk("rst_y_nave", bus.y_nave, 440);
    chk("rst_x_ini", bus.x_inimigo, 0);
    chk("rst_y_ini", bus.y_inimigo, 40);
    chk("rst_raio_a", bus.raio_bola_aliada, 0);
    chk("rst_raio_i", bus.raio_bola_inimiga, 0);
    chk("rst_xa", bus.x_bola_aliada, 0);
    chk("rst_yi", bus.y_bola_inimiga, 0);
    chk("rst_pontos", bus.pontos, 0);
    chk("rst_perdeu", bus.perdeu, 0);
    chk("rst_ocupado", bus.ocupado, 0);

    // Pulse ignored while ativo=0
    bus.ativo = 1'b0;
    bus.inicio_quadro = 1'b1;
    tick();
    bus.inicio_quadro = 1'b0;
    chk("inativo_ocupado", bus.ocupado, 0);
    tick();
    chk("inativo_x_ini", bus.x_inimigo, 0);
    bus.ativo = 1'b1;

    // First frame: ocupado high for exactly 5 cycles
    bus.inicio_quadro = 1'b1;
    tick();
    bus.inicio_quadro = 1'b0;
    busy = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.ocupado) busy++;
      tick();
    end
    chk("ocupado_ciclos", busy, 5);
    chk("f1_x_nave", bus.x_nave, 305);
    chk("f1_x_ini", bus.x_inimigo, 2);

    // Ship movement and clamping
    do_reset();
    bus.botao_dir = 1'b1;
    frames(3);
    chk("dir3_x_nave", bus.x_nave, 317);
    frames(100);
    chk("dir103_x_nave", bus.x_nave, 610);
    bus.botao_esq = 1'b1;
    frames(2);
    chk("ambos_x_nave", bus.x_nave, 610);
    bus.botao_dir = 1'b0;
    frames(152);
    chk("esq_x_nave_2", bus.x_nave, 2);
    frames(1);
    chk("esq_x_nave_0", bus.x_nave, 0);
    chk("esq_perdeu", bus.perdeu, 0);
    bus.botao_esq = 1'b0;

    // Ally shot spawn, flight, exit; enemy shot and bounce
    do_reset();
    bus.botao_tiro = 1'b1;
    frames(1);
    chk("spawn_xa", bus.x_bola_aliada, 320);
    chk("spawn_ya", bus.y_bola_aliada, 436);
    chk("spawn_raio_a", bus.raio_bola_aliada, 4);
    frames(1);
    chk("voo_ya", bus.y_bola_aliada, 428);
    chk("voo_xa", bus.x_bola_aliada, 320);
    frames(53);
    chk("f55_ya", bus.y_bola_aliada, 4);
    chk("f55_raio_a", bus.raio_bola_aliada, 4);
    frames(1);
    chk("saida_raio_a", bus.raio_bola_aliada, 0);
    chk("saida_ya", bus.y_bola_aliada, 4);
    bus.botao_tiro = 1'b0;
    frames(3);
    chk("f59_raio_i", bus.raio_bola_inimiga, 0);
    frames(1);
    chk("f60_x_ini", bus.x_inimigo, 120);
    chk("f60_xi", bus.x_bola_inimiga, 135);
    chk("f60_yi", bus.y_bola_inimiga, 72);
    chk("f60_raio_i", bus.raio_bola_inimiga, 4);
    frames(1);
    chk("f61_yi", bus.y_bola_inimiga, 76);
    frames(243);
    chk("f304_x_ini", bus.x_inimigo, 608);
    frames(1);
    chk("f305_x_ini", bus.x_inimigo, 610);
    frames(1);
    chk("f306_x_ini", bus.x_inimigo, 608);
    chk("f306_pontos", bus.pontos, 0);

    // Ally shot hits the enemy at frame 146 (enemy x=292, shot 320,68)
    do_reset();
    frames(99);
    bus.botao_tiro = 1'b1;
    frames(1);
    bus.botao_tiro = 1'b0;
    frames(45);
    chk("f145_ya", bus.y_bola_aliada, 76);
    chk("f145_pontos", bus.pontos, 0);
    frames(1);
    chk("hit_pontos", bus.pontos, 1);
    chk("hit_raio_a", bus.raio_bola_aliada, 0);
    chk("hit_ya", bus.y_bola_aliada, 68);

    // Ship at x=129 under the enemy shot x=135: loss at frame 152
    do_reset();
    bus.botao_esq = 1'b1;
    frames(44);
    bus.botao_esq = 1'b0;
    chk("perda_x_nave", bus.x_nave, 129);
    frames(107);
    chk("f151_perdeu", bus.perdeu, 0);
    chk("f151_yi", bus.y_bola_inimiga, 436);
    frames(1);
    chk("f152_perdeu", bus.perdeu, 1);
    chk("f152_raio_i", bus.raio_bola_inimiga, 0);
    chk("f152_yi", bus.y_bola_inimiga, 440);
    bus.botao_dir = 1'b1;
    bus.inicio_quadro = 1'b1;
    tick();
    bus.inicio_quadro = 1'b0;
    chk("perdeu_ocupado", bus.ocupado, 0);
    frames(2);
    bus.botao_dir = 1'b0;
    chk("perdeu_x_nave", bus.x_nave, 129);
    chk("perdeu_x_ini", bus.x_inimigo, 304);
    chk("perdeu_yi", bus.y_bola_inimiga, 440);
    chk("perdeu_fixo", bus.perdeu, 1);

    // Second pulse during the sequence is dropped
    do_reset();
    bus.inicio_quadro = 1'b1;
    tick();
    bus.inicio_quadro = 1'b0;
    tick();
    tick();
    bus.inicio_quadro = 1'b1;
    tick();
    bus.inicio_quadro = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("drop_x_ini", bus.x_inimigo, 2);
    chk("drop_ocupado", bus.ocupado, 0);

    // Reset asserted while in INIMIGO
    bus.botao_dir = 1'b1;
    bus.inicio_quadro = 1'b1;
    tick();
    bus.inicio_quadro = 1'b0;
    tick();
    tick();
    chk("mid_x_nave_movida", bus.x_nave, 309);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.botao_dir = 1'b0;
    chk("mid_x_nave", bus.x_nave, 305);
    chk("mid_x_ini", bus.x_inimigo, 0);
    chk("mid_ocupado", bus.ocupado, 0);
    tick();
    chk("mid_ocioso", bus.ocupado, 0);
    frames(1);
    chk("mid_apos_x_ini", bus.x_inimigo, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/escalonador_quadro.md
Name: escalonador_quadro

Overview:
- Per-frame game-state controller for the shooter display.
- Once per video frame, a single-cycle pulse starts a fixed update sequence: ship, ally shot, enemy, enemy shot, collisions.
- The sequence drives the object coordinates, radii and `perdeu` consumed by the pixel renderer.
- All coordinates are active-area pixels, x 0..639 and y 0..479; the renderer adds the sync offsets.

Parameters:
- VEL_NAVE, 4, ship x step per frame.
- VEL_TIRO, 8, ally shot upward step per frame.
- VEL_INIMIGO, 2, enemy x step per frame.
- VEL_TIRO_INIMIGO, 4, enemy shot downward step per frame.
- PERIODO_TIRO, 60, frames between enemy shot attempts.
- LARGURA_OBJ, 30, ship/enemy box width.
- ALTURA_OBJ, 32, ship/enemy box height.
- RAIO, 4, shot radius when active.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- inicio_quadro  in  1  one-cycle pulse per frame, already synchronous to CLOCK_50.
- ativo  in  1  game running; while 0, pulses are ignored.
- botao_esq / botao_dir / botao_tiro  in  1 each  level inputs, sampled in their state.
- x_nave, y_nave  out  10 each  ship top-left.
- x_inimigo, y_inimigo  out  10 each  enemy top-left.
- x_bola_aliada, y_bola_aliada, raio_bola_aliada  out  10 each  ally shot.
- x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga  out  10 each  enemy shot.
- pontos  out  8  hit counter.
- perdeu  out  1  sticky loss flag.
- ocupado  out  1  high while the sequence runs.

Behaviour:
- Clock and reset: one clock, CLOCK_50; reset is synchronous and active-high. All state changes on the rising edge.
- Reset values:
  - Ship: x_nave=305, y_nave=440.
  - Enemy: x_inimigo=0, y_inimigo=40, direction right.
  - Shots: both inactive, coordinates 0, radii 0.
  - Counters and flags: pontos=0, perdeu=0, ocupado=0, frame counter 0, FSM OCIOSO.
- Reset wins over any state, including mid-sequence.
- FSM: OCIOSO -> NAVE -> TIRO -> INIMIGO -> TIRO_INI -> COLISAO -> OCIOSO, one cycle per state.
  - Leaves OCIOSO only on inicio_quadro=1, ativo=1 and perdeu=0.
  - ocupado=1 in every state except OCIOSO, so it is high for exactly 5 cycles.
  - inicio_quadro arriving while ocupado=1 is dropped, not queued.
- NAVE:
  - botao_dir alone: x_nave += VEL_NAVE, clamped to 640-LARGURA_OBJ=610.
  - botao_esq alone: x_nave -= VEL_NAVE, clamped to 0 with no unsigned underflow.
  - Both or neither pressed: no change. y_nave is constant.
- TIRO:
  - Ally shot active: if y_bola_aliada < VEL_TIRO, deactivate (raio=0); else y -= VEL_TIRO.
  - Ally shot inactive and botao_tiro=1: spawn at (x_nave+15, y_nave-4) with raio=RAIO, no movement this frame.
- INIMIGO:
  - Moving right: x += VEL_INIMIGO; if the result is >= 610, set x=610 and reverse direction.
  - Moving left: if x <= VEL_INIMIGO, set x=0 and reverse direction; else x -= VEL_INIMIGO.
- TIRO_INI:
  - Enemy shot active: if y+VEL_TIRO_INIMIGO > 475, deactivate; else y += VEL_TIRO_INIMIGO.
  - Frame counter: increments each frame, saturating at PERIODO_TIRO-1.
  - Spawn when the counter is at PERIODO_TIRO-1 and the enemy shot is inactive (checked before this frame's move): spawn at (x_inimigo+15, y_inimigo+32) with raio=RAIO, counter cleared to 0.
- COLISAO (each test uses the shot center against the object box, half-open: x0 <= x < x0+LARGURA_OBJ, y0 <= y < y0+ALTURA_OBJ):
  - Active ally shot inside the enemy box: deactivate the shot; pontos += 1, saturating at 255.
  - Active enemy shot inside the ship box: deactivate the shot; perdeu=1, held until reset.
  - Both tests are evaluated in the same cycle; both effects apply when both hit.
- Inactive shots keep their last coordinates with raio=0, so the renderer draws nothing.
- Outputs are registered; the renderer must treat values as frame-consistent only while ocupado=0.

Test Plan:
- Reset values and frame timing: reset, then one frame pulse with no buttons -> x_nave=305, x_inimigo=2; ocupado high for exactly 5 cycles then low.
- Ship movement and clamping: hold botao_dir for 3 frames -> x_nave=317. Hold it for 100 frames -> x_nave=610 and stays. Both buttons held -> no change. Hold botao_esq from x=2 -> x_nave=0.
- Ally shot spawn and exit:
  - botao_tiro at x_nave=305 -> shot spawns at (320,436) with raio 4.
  - Next frame -> y=428.
  - Holding botao_tiro during flight spawns nothing new.
  - Shot leaves the top at frame 55 after spawn -> raio 0.
- Enemy bounce and enemy shot:
  - x_inimigo reaches 610 at frame 305, then decreases by 2 per frame.
  - First enemy shot spawns at frame 60 at (x_inimigo+15, 72) and descends 4 per frame.
- Hit and loss:
  - Ally shot center entering the enemy box -> pontos 0->1 and raio_bola_aliada=0 in the same COLISAO cycle.
  - Ship placed under the enemy shot -> perdeu=1 after 92 frames; later frame pulses leave all coordinates unchanged.
- Dropped pulse and mid-sequence reset: a second inicio_quadro 2 cycles after the first -> only one update applied. Reset asserted in INIMIGO -> all reset values on the next edge, FSM in OCIOSO.
